// File: rtl/mt_regfile.sv
// Multi-threaded register file: one bank per hardware thread, two combinational
// read ports with write bypass, one write port, and a per-bank clear sequencer.
// Optional: define ZERO_REG_EN to hardwire index 0 of every bank to zero.
module mt_regfile #(
  parameter int unsigned               DATAPATH_WIDTH     = 64,
  parameter int unsigned               REGFILE_ADDR_WIDTH = 5,
  parameter int unsigned               NUM_THREADS        = 4,
  parameter int unsigned               TID_WIDTH          = 2,
  parameter logic [DATAPATH_WIDTH-1:0] RESET_VALUE        = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [TID_WIDTH-1:0]          R1_tid_in,
  input  logic [REGFILE_ADDR_WIDTH-1:0] R1_addr_in,
  output logic [DATAPATH_WIDTH-1:0]     R1_data_out,
  input  logic [TID_WIDTH-1:0]          R2_tid_in,
  input  logic [REGFILE_ADDR_WIDTH-1:0] R2_addr_in,
  output logic [DATAPATH_WIDTH-1:0]     R2_data_out,
  input  logic [TID_WIDTH-1:0]          WR_tid_in,
  input  logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_in,
  input  logic [DATAPATH_WIDTH-1:0]     WR_data_in,
  input  logic                          wena,
  input  logic                          clr_req,
  input  logic [TID_WIDTH-1:0]          clr_tid,
  output logic                          clr_busy,
  output logic                          clr_done,
  output logic                          wr_drop
);

  localparam int unsigned DEPTH = 2**REGFILE_ADDR_WIDTH;
`ifdef ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_e;

  state_e                        state_q, state_d;
  logic [REGFILE_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [TID_WIDTH-1:0]          ctid_q, ctid_d;
  logic                          wr_drop_q, wr_drop_d;
  logic [DATAPATH_WIDTH-1:0]     mem_q [NUM_THREADS][DEPTH];

  logic wr_tid_ok, clr_tid_ok, wr_zero, ext_we, clr_we;

  assign wr_tid_ok  = 32'(WR_tid_in) < NUM_THREADS;
  assign clr_tid_ok = 32'(clr_tid) < NUM_THREADS;
  assign wr_zero    = ZeroReg && (WR_addr_in == '0);
  assign wr_drop    = wr_drop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ctid_q    <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctid_q    <= ctid_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // DONE behaves like IDLE for new requests so clears can run back to back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctid_d  = ctid_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (clr_req && clr_tid_ok) begin
          state_d = CLEAR;
          ctid_d  = clr_tid;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Any write that is neither performed nor a silent zero-register write is flagged.
  always_comb begin
    clr_busy  = (state_q == CLEAR);
    clr_done  = (state_q == DONE);
    clr_we    = clr_busy && !reset;
    ext_we    = !reset && wena && (state_q == IDLE) && wr_tid_ok && !wr_zero;
    wr_drop_d = wena && !wr_zero && ((state_q != IDLE) || !wr_tid_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: RESET_VALUE};
    end else if (ext_we) begin
      mem_q[WR_tid_in][WR_addr_in] <= WR_data_in;
    end else if (clr_we) begin
      mem_q[ctid_q][cnt_q] <= RESET_VALUE;
    end
  end

  function automatic logic [DATAPATH_WIDTH-1:0] rd_port(
    input logic [TID_WIDTH-1:0]          tid,
    input logic [REGFILE_ADDR_WIDTH-1:0] addr
  );
    logic [DATAPATH_WIDTH-1:0] d;
    if (32'(tid) >= NUM_THREADS)                         d = RESET_VALUE;
    else if (ZeroReg && addr == '0)                      d = '0;
    else if (ext_we && tid == WR_tid_in && addr == WR_addr_in) d = WR_data_in;
    else if (clr_we && tid == ctid_q && addr == cnt_q)   d = RESET_VALUE;
    else                                                 d = mem_q[tid][addr];
    return d;
  endfunction

  always_comb begin
    R1_data_out = rd_port(R1_tid_in, R1_addr_in);
    R2_data_out = rd_port(R2_tid_in, R2_addr_in);
  end

endmodule
